// File: rtl/orv64_param_pkg.sv
// Global ORV64 parameters shared by the memory-side blocks.
//   PHY_ADDR_WIDTH        physical address width
//   XLEN                  data path width
//   MAGICMEM_OURSBUS_ID   top-6-bit address tag that selects the magic memory
//   MAGICMEM_ARB_TIMEOUT  default WAIT-state limit for orv64_magicmem_arb
package orv64_param_pkg;

    localparam int unsigned PHY_ADDR_WIDTH       = 56;
    localparam int unsigned XLEN                 = 64;
    localparam logic [5:0]  MAGICMEM_OURSBUS_ID  = 6'h01;
    localparam int unsigned MAGICMEM_ARB_TIMEOUT = 64;

endpackage

// File: rtl/orv64_typedef_pkg.sv
// Shared ORV64 types: address/data words, the magic-memory arbiter state
// encoding and the latched request payload that is presented on oursbus.
package orv64_typedef_pkg;

    import orv64_param_pkg::*;

    typedef logic [PHY_ADDR_WIDTH-1:0] paddr_t;
    typedef logic [XLEN-1:0]           data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mm_arb_state_t;

    // Request payload held on the oursbus port for a whole transaction
    typedef struct packed {
        logic   rwn;
        paddr_t addr;
        data_t  wdata;
    } mm_arb_req_t;

endpackage

// File: rtl/orv64_rr_pick.sv
// Combinational N-way round-robin selector.
// Searches i_req starting at i_ptr and wrapping, lowest index first from the
// pointer; reports the winner as one-hot and as an index.
//   i_req      request vector
//   i_ptr      index with highest priority this cycle
//   o_grant_c  one-hot grant (all zero when nothing requests)
//   o_idx_c    winner index (0 when nothing requests)
//   o_valid_c  at least one request present
module orv64_rr_pick #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant_c,
    output logic [IW-1:0] o_idx_c,
    output logic          o_valid_c
);

    logic [IW-1:0] w_cand;

    // (ptr + off) mod N; the sum never exceeds 2N-2 so IW+1 bits suffice
    function automatic logic [IW-1:0] f_wrap(input logic [IW:0] a);
        return IW'(a % N);
    endfunction

    // First requester at or after the pointer wins
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        w_cand    = '0;
        for (int unsigned off = 0; off < N; off++) begin
            w_cand = f_wrap((IW+1)'(i_ptr) + (IW+1)'(off));
            if (!o_valid_c && i_req[w_cand]) begin
                o_valid_c = 1'b1;
                o_idx_c   = w_cand;
            end
        end
        o_grant_c[o_idx_c] = o_valid_c;
    end

endmodule

// File: rtl/orv64_magicmem_arb.sv
// Round-robin arbiter that serialises N requesters onto the single oursbus
// request port of the magic memory, one outstanding transaction at a time.
// Requests whose top 6 address bits are not MAGICMEM_OURSBUS_ID are answered
// at once with an error and never reach the bus.
//
// Optional build macro ORV64_MAGICMEM_ARB_TIMEOUT_EN: WAIT gives up after
// TIMEOUT_CYCLES cycles without ob_resp and answers with an error.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   i_req_valid/rwn/addr/wdata   per-requester request (held until response)
//   o_resp_valid          one-hot, single-cycle response strobe
//   o_resp_err/rdata      response qualifiers, valid with o_resp_valid
//   o_ob_req              single-cycle request pulse to magic memory
//   o_ob_rwn/addr/wdata   request payload, held ISSUE through RESP
//   i_ob_rdata/resp/resp_err     magic memory response
module orv64_magicmem_arb
    import orv64_param_pkg::*;
    import orv64_typedef_pkg::*;
#(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = MAGICMEM_ARB_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [N_REQ-1:0] i_req_rwn,
    input  paddr_t           i_req_addr  [N_REQ],
    input  data_t            i_req_wdata [N_REQ],
    output logic [N_REQ-1:0] o_resp_valid,
    output logic             o_resp_err,
    output data_t            o_resp_rdata,
    output logic             o_ob_req,
    output logic             o_ob_rwn,
    output paddr_t           o_ob_addr,
    output data_t            o_ob_wdata,
    input  data_t            i_ob_rdata,
    input  logic             i_ob_resp,
    input  logic             i_ob_resp_err
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    mm_arb_state_t    r_state,      w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr,     w_rr_ptr_nxt;
    logic [IDX_W-1:0] r_win_idx,    w_win_idx_nxt;
    mm_arb_req_t      r_ob,         w_ob_nxt;
    logic             r_ob_req,     w_ob_req_nxt;
    logic [N_REQ-1:0] r_resp_valid, w_resp_valid_nxt;
    logic             r_resp_err,   w_resp_err_nxt;
    data_t            r_resp_rdata, w_resp_rdata_nxt;

    logic [N_REQ-1:0] w_pick_grant;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic             w_pick_hit;
    logic [N_REQ-1:0] w_win_onehot;
    logic             w_timeout;

    orv64_rr_pick #(
        .N (N_REQ)
    ) u_rr_pick (
        .i_req     (i_req_valid),
        .i_ptr     (r_rr_ptr),
        .o_grant_c (w_pick_grant),
        .o_idx_c   (w_pick_idx),
        .o_valid_c (w_pick_valid)
    );

    assign w_pick_hit   = (i_req_addr[w_pick_idx][PHY_ADDR_WIDTH-1 -: 6] == MAGICMEM_OURSBUS_ID);
    assign w_win_onehot = N_REQ'(1) << r_win_idx;

`ifdef ORV64_MAGICMEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle (counter is 0 on the first)
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == ISSUE) begin
            w_cnt_nxt = '0;
        end else if (r_state == WAIT) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_timeout          = 1'b0;
`endif

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_win_idx_nxt    = r_win_idx;
        w_ob_nxt         = r_ob;
        w_ob_req_nxt     = 1'b0;
        w_resp_valid_nxt = '0;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = r_resp_rdata;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_win_idx_nxt  = w_pick_idx;
                    w_rr_ptr_nxt   = (w_pick_idx == IDX_W'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
                    w_ob_nxt.rwn   = i_req_rwn[w_pick_idx];
                    w_ob_nxt.addr  = i_req_addr[w_pick_idx];
                    w_ob_nxt.wdata = i_req_wdata[w_pick_idx];
                    if (w_pick_hit) begin
                        w_state_nxt  = ISSUE;
                        w_ob_req_nxt = 1'b1;
                    end else begin
                        // Not a magic-memory address: answer immediately
                        w_state_nxt      = RESP;
                        w_resp_valid_nxt = w_pick_grant;
                        w_resp_err_nxt   = 1'b1;
                        w_resp_rdata_nxt = '0;
                    end
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (i_ob_resp) begin
                    w_state_nxt      = RESP;
                    w_resp_valid_nxt = w_win_onehot;
                    w_resp_err_nxt   = i_ob_resp_err;
                    w_resp_rdata_nxt = i_ob_rdata;
                end else if (w_timeout) begin
                    w_state_nxt      = RESP;
                    w_resp_valid_nxt = w_win_onehot;
                    w_resp_err_nxt   = 1'b1;
                    w_resp_rdata_nxt = '0;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_ob_nxt    = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_ob_nxt    = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_win_idx    <= '0;
            r_ob         <= '0;
            r_ob_req     <= 1'b0;
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_win_idx    <= w_win_idx_nxt;
            r_ob         <= w_ob_nxt;
            r_ob_req     <= w_ob_req_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_resp_rdata = r_resp_rdata;
    assign o_ob_req     = r_ob_req;
    assign o_ob_rwn     = r_ob.rwn;
    assign o_ob_addr    = r_ob.addr;
    assign o_ob_wdata   = r_ob.wdata;

endmodule

// File: doc/orv64_magicmem_arb.md
Name: orv64_magicmem_arb

Overview:
- Arbitrates N requesters (core LSU, debug/host loader, etc.) onto the single oursbus request port of the magic memory.
- Serialises accesses: one outstanding transaction at a time.
- Drives a single-cycle ob_req pulse and holds address, data and rwn stable until ob_resp.
- Rejects requests whose top 6 address bits are not MAGICMEM_OURSBUS_ID with an immediate error response.

Parameters:
N_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  per-requester request; held high until that requester's resp_valid
req_rwn  in  N_REQ  1 = read, 0 = write
req_addr  in  N_REQ x paddr_t  physical address
req_wdata  in  N_REQ x data_t  write data
resp_valid  out  N_REQ  one-hot, one-cycle response strobe
resp_err  out  1  error qualifier, valid with resp_valid
resp_rdata  out  data_t  read data, valid with resp_valid
ob_req  out  1  request pulse to magic memory
ob_rwn  out  1  held for the whole transaction
ob_addr  out  paddr_t  held for the whole transaction
ob_wdata  out  data_t  held for the whole transaction
ob_rdata  in  data_t  magic memory read data
ob_resp  in  1  magic memory response strobe
ob_resp_err  in  1  magic memory error

Behaviour:
- Reset (async, immediate): state IDLE, rr_ptr=0, all outputs 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid: select winner by round-robin starting at rr_ptr, lowest index first from there.
  - Latch winner index, rwn, addr and wdata into registers; set rr_ptr = winner+1 mod N_REQ.
  - If addr[PHY_ADDR_WIDTH-1 -: 6] == MAGICMEM_OURSBUS_ID, go to ISSUE; otherwise go to RESP with err=1, rdata=0.
- ISSUE: ob_req=1 for exactly one cycle, then WAIT. ob_req is never high in any other state, since the magic memory retriggers on a held ob_req.
- WAIT:
  - ob_req=0; ob_addr/ob_rwn/ob_wdata are driven from latched registers in ISSUE, WAIT and RESP, and are 0 in IDLE.
  - On ob_resp: capture ob_rdata and ob_resp_err, go to RESP.
- RESP: resp_valid[winner]=1 and resp_err/resp_rdata from captured values for one cycle, then IDLE.
- Requester contract:
  - Drop req_valid the cycle after resp_valid; the arbiter does not sample req_valid in RESP.
  - Changing req_* while req_valid is high and before resp_valid has no effect once latched.
- Latency, magic-memory hit: req_valid in IDLE at cycle 0 -> ob_req at cycle 1 -> ob_resp at cycle 3 -> resp_valid at cycle 4. Back-to-back throughput is one transaction per 5 cycles.
- Rejected (non-magic-mem ID): resp_valid with err=1 at cycle 1.
- ob_resp outside WAIT: ignored, no state change.
- resp_rdata holds its last value outside RESP; resp_err is 0 outside RESP.
- A requester dropping req_valid after it has been latched still completes: the response strobe is issued and the requester ignores it.
- Reset mid-transaction: the arbiter returns to IDLE. The magic memory shares rst, so no stray response follows.

Optional Feature:
- Macro ORV64_MAGICMEM_ARB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on ISSUE and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without ob_resp, go to RESP with err=1, rdata=0.
  - A later stray ob_resp is ignored per the rule above.
- Undefined: no counter; WAIT persists until ob_resp.

Decomposition:
- orv64_param_pkg: MAGICMEM_OURSBUS_ID and PHY_ADDR_WIDTH (existing); add MAGICMEM_ARB_TIMEOUT default.
- orv64_typedef_pkg: paddr_t and data_t (existing); add typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mm_arb_state_t.
- One sub-module: orv64_rr_pick, combinational N-way round-robin selector (req vector and pointer in, one-hot grant and index out). It is reusable elsewhere.

Test Plan:
- Single read: req_valid[0], addr=magic-mem base+0x8 -> ob_req high only at cycle 1; ob_addr stable cycles 1-4; resp_valid[0] at cycle 4 with rdata = ob_rdata.
- Contention: req_valid[0] and req_valid[1] both high continuously, rr_ptr=0 -> grant order 0,1,0,1; each transaction separated by 5 cycles.
- Bad target: req_valid[1] with top 6 address bits != MAGICMEM_OURSBUS_ID -> no ob_req; resp_valid[1] at cycle 1 with resp_err=1, rdata=0.
- Write: req_rwn=0, wdata=0xDEADBEEF_CAFEF00D -> ob_rwn=0 and ob_wdata equal to that value from ISSUE through RESP; resp_err=0.
- Async reset asserted in WAIT -> all outputs 0 immediately without a clock edge; after release, first grant goes to requester 0.
- With ORV64_MAGICMEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, ob_resp held low -> resp_valid with resp_err=1 exactly 4 WAIT cycles after ISSUE; a later ob_resp pulse is ignored.
